// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program run controller: FSM state encoding
// and default widths/limits used by the sequencer and its helpers.
package program_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      RUN,
      DRAIN,
      NEXT,
      FINISH
   } seq_state_t;

   localparam int DEF_PC_BITS        = 9;
   localparam int DEF_NUM_PROGS      = 3;
   localparam int DEF_PIDX_W         = 2;
   localparam int DEF_CYC_W          = 16;
   localparam int DEF_TIMEOUT_CYCLES = 4096;
   localparam int DEF_LAUNCH_CYCLES  = 2;
   localparam int DEF_DRAIN_CYCLES   = 1;

   // Width of the shared LAUNCH/DRAIN phase counter.
   localparam int PHASE_W = 8;

endpackage

// File: rtl/program_sequencer_next_prog_finder.sv
// Combinational search for the next enabled program slot: either the lowest
// set mask bit (first=1) or the lowest set bit strictly above cur.
module next_prog_finder
   import program_sequencer_pkg::*;
#(
   parameter int NUM_PROGS = DEF_NUM_PROGS,
   parameter int PIDX_W    = DEF_PIDX_W
) (
   input  logic [NUM_PROGS-1:0] mask,
   input  logic [PIDX_W-1:0]    cur,
   input  logic                 first,
   output logic                 found,
   output logic [PIDX_W-1:0]    idx
);

   logic [NUM_PROGS-1:0] cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PROGS; gi++) begin : g_cand
         assign cand[gi] = mask[gi] & (first | (PIDX_W'(gi) > cur));
      end
   endgenerate

   // Scan downward so the lowest qualifying slot is the one that sticks.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NUM_PROGS - 1; i >= 0; i--) begin
         if (cand[i]) begin
            found = 1'b1;
            idx   = PIDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// Run controller in front of the single-cycle processor: launches each masked
// program from its entry address, waits for halt or watchdog, reports results.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int PC_BITS        = DEF_PC_BITS,
   parameter int NUM_PROGS      = DEF_NUM_PROGS,
   parameter int PIDX_W         = DEF_PIDX_W,
   parameter int CYC_W          = DEF_CYC_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int LAUNCH_CYCLES  = DEF_LAUNCH_CYCLES,
   parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_PROGS-1:0]         prog_mask,
   input  logic [NUM_PROGS*PC_BITS-1:0] entry_addr,
   input  logic                         cpu_halt,
   output logic                         cpu_start,
   output logic [PC_BITS-1:0]           starting_address,
   output logic [PIDX_W-1:0]            prog_idx,
   output logic                         busy,
   output logic                         run_valid,
   output logic [CYC_W-1:0]             cycle_count,
   output logic                         timeout,
   output logic                         done
);

   seq_state_t                   state_reg, state_next;
   logic [NUM_PROGS-1:0]         mask_reg, mask_next;
   logic [NUM_PROGS*PC_BITS-1:0] entry_reg, entry_next;
   logic [PHASE_W-1:0]           phase_reg, phase_next;
   logic [PIDX_W-1:0]            prog_idx_reg, prog_idx_next;
   logic [PC_BITS-1:0]           start_addr_reg, start_addr_next;
   logic                         cpu_start_reg, cpu_start_next;
   logic                         busy_reg, busy_next;
   logic                         run_valid_reg, run_valid_next;
   logic [CYC_W-1:0]             cycle_count_reg, cycle_count_next;
   logic                         timeout_reg, timeout_next;
   logic                         done_reg, done_next;

   // In IDLE the search and address lookup use the live inputs so the first
   // launch is set up on the same edge that accepts start.
   logic                         in_idle;
   logic [NUM_PROGS-1:0]         find_mask;
   logic [NUM_PROGS*PC_BITS-1:0] entry_src;
   logic                         find_found;
   logic [PIDX_W-1:0]            find_idx;
   logic [PC_BITS-1:0]           find_addr;

   assign in_idle   = (state_reg == IDLE);
   assign find_mask = in_idle ? prog_mask : mask_reg;
   assign entry_src = in_idle ? entry_addr : entry_reg;
   assign find_addr = entry_src[int'(find_idx)*PC_BITS +: PC_BITS];

   next_prog_finder #(
      .NUM_PROGS (NUM_PROGS),
      .PIDX_W    (PIDX_W)
   ) u_finder (
      .mask  (find_mask),
      .cur   (prog_idx_reg),
      .first (in_idle),
      .found (find_found),
      .idx   (find_idx)
   );

   always_comb begin
      state_next       = state_reg;
      mask_next        = mask_reg;
      entry_next       = entry_reg;
      phase_next       = phase_reg;
      prog_idx_next    = prog_idx_reg;
      start_addr_next  = start_addr_reg;
      cycle_count_next = cycle_count_reg;
      timeout_next     = timeout_reg;
      done_next        = done_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               mask_next    = prog_mask;
               entry_next   = entry_addr;
               timeout_next = 1'b0;
               if (!find_found) begin
                  state_next = FINISH;
                  done_next  = 1'b1;
               end else begin
                  done_next        = 1'b0;
                  state_next       = LAUNCH;
                  prog_idx_next    = find_idx;
                  start_addr_next  = find_addr;
                  cycle_count_next = '0;
                  phase_next       = '0;
               end
            end
         end
         LAUNCH: begin
            if (phase_reg == PHASE_W'(LAUNCH_CYCLES - 1)) begin
               state_next       = RUN;
               cycle_count_next = CYC_W'(1);
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         RUN: begin
            // Halt takes priority over the watchdog in the same cycle.
            if (cpu_halt) begin
               state_next = DRAIN;
               phase_next = '0;
            end else if (cycle_count_reg == CYC_W'(TIMEOUT_CYCLES)) begin
               state_next   = DRAIN;
               phase_next   = '0;
               timeout_next = 1'b1;
            end else begin
               cycle_count_next = cycle_count_reg + 1'b1;
            end
         end
         DRAIN: begin
            if (phase_reg == PHASE_W'(DRAIN_CYCLES - 1)) begin
               state_next = NEXT;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         NEXT: begin
            if (find_found) begin
               state_next       = LAUNCH;
               prog_idx_next    = find_idx;
               start_addr_next  = find_addr;
               cycle_count_next = '0;
               phase_next       = '0;
            end else begin
               state_next = FINISH;
               done_next  = 1'b1;
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Status outputs are decoded from the upcoming state so they register
      // in step with it.
      cpu_start_next = (state_next == LAUNCH);
      busy_next      = (state_next == LAUNCH) || (state_next == RUN) ||
                       (state_next == DRAIN)  || (state_next == NEXT);
      run_valid_next = (state_next == DRAIN) &&
                       (phase_next == PHASE_W'(DRAIN_CYCLES - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         mask_reg        <= '0;
         entry_reg       <= '0;
         phase_reg       <= '0;
         prog_idx_reg    <= '0;
         start_addr_reg  <= '0;
         cpu_start_reg   <= 1'b0;
         busy_reg        <= 1'b0;
         run_valid_reg   <= 1'b0;
         cycle_count_reg <= '0;
         timeout_reg     <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         mask_reg        <= mask_next;
         entry_reg       <= entry_next;
         phase_reg       <= phase_next;
         prog_idx_reg    <= prog_idx_next;
         start_addr_reg  <= start_addr_next;
         cpu_start_reg   <= cpu_start_next;
         busy_reg        <= busy_next;
         run_valid_reg   <= run_valid_next;
         cycle_count_reg <= cycle_count_next;
         timeout_reg     <= timeout_next;
         done_reg        <= done_next;
      end
   end

   assign cpu_start        = cpu_start_reg;
   assign starting_address = start_addr_reg;
   assign prog_idx         = prog_idx_reg;
   assign busy             = busy_reg;
   assign run_valid        = run_valid_reg;
   assign cycle_count      = cycle_count_reg;
   assign timeout          = timeout_reg;
   assign done             = done_reg;

endmodule
